clkdiv_multi: RTL

- Multi-channel programmable clock divider and tick generator for the PWM/servo timing path.
- Each of NUM_CH channels produces a 50% square output and a one-cycle tick per period.
- Half-period divisors can be changed at runtime through a write port; changes are glitch-free and applied only at period boundaries.
- A global sync input phase-aligns all channels.

---
 rtl/clkdiv_pkg.sv | 24 ++
 rtl/clkdiv_channel.sv | 96 +++++++++
 rtl/clkdiv_multi.sv | 57 +++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// The optional per-channel tick counter is enabled with CLKDIV_CYCLE_CNT_EN.
package clkdiv_pkg;

    localparam int unsigned CLK_FREQ_DEFAULT = 50_000_000;
    localparam int          CYC_CNT_W        = 16;

    // Width of a channel index; never below one bit so a single channel still has a port.
    function automatic int ch_idx_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Half-period in clock cycles for a target output frequency, truncated.
    function automatic int unsigned half_from_freq(
        input int unsigned freq,
        input int unsigned clk_freq = CLK_FREQ_DEFAULT
    );
        if (freq == 0) begin
            return 0;
        end
        return clk_freq / (2 * freq);
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: half-period counter, active/shadow divisor and registered outputs.
// With CLKDIV_CYCLE_CNT_EN a 16-bit tick counter is added.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int          CNT_W        = 32,
    parameter int unsigned DEFAULT_HALF = 500_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_val,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
`ifdef CLKDIV_CYCLE_CNT_EN
   ,output logic [CYC_CNT_W-1:0] cycle_cnt
`endif
);

    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] shadow;
    logic             running;
    logic             half_done;
    logic             tick_set;

    assign running   = en && (half != '0);
    assign half_done = (count == half - 1'b1);
    assign tick_set  = !sync && running && half_done && !clk_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            half    <= RST_HALF;
            shadow  <= RST_HALF;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
        end else begin
            tick <= tick_set;
            if (sync) begin
                // A write in the sync cycle bypasses the shadow and takes effect at once.
                count   <= '0;
                clk_out <= 1'b0;
                pending <= 1'b0;
                if (wr) begin
                    half   <= wr_val;
                    shadow <= wr_val;
                end else begin
                    half <= shadow;
                end
            end else begin
                if (!running) begin
                    count   <= '0;
                    clk_out <= 1'b0;
                    if (pending) begin
                        half    <= shadow;
                        pending <= 1'b0;
                    end
                end else if (half_done) begin
                    count   <= '0;
                    clk_out <= !clk_out;
                    if (clk_out && pending) begin
                        half    <= shadow;
                        pending <= 1'b0;
                    end
                end else begin
                    count <= count + 1'b1;
                end
                // Placed last so a same-cycle write stays pending after any load above.
                if (wr) begin
                    shadow  <= wr_val;
                    pending <= 1'b1;
                end
            end
        end
    end

`ifdef CLKDIV_CYCLE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else if (sync) begin
            cycle_cnt <= '0;
        end else if (tick_set) begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider / tick generator with runtime divisor updates.
// Define CLKDIV_CYCLE_CNT_EN to add the per-channel cycle_cnt output.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = 32,
    parameter int unsigned CLK_FREQ     = CLK_FREQ_DEFAULT,
    parameter int unsigned DEFAULT_HALF = half_from_freq(50, CLK_FREQ),
    localparam int         CH_IDX_W     = ch_idx_width(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   en,
    input  logic                sync,
    input  logic                div_wr,
    input  logic [CH_IDX_W-1:0] div_ch,
    input  logic [CNT_W-1:0]    div_val,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [NUM_CH-1:0]   tick,
    output logic [NUM_CH-1:0]   pending
`ifdef CLKDIV_CYCLE_CNT_EN
   ,output logic [NUM_CH*CYC_CNT_W-1:0] cycle_cnt
`endif
);

    logic [NUM_CH-1:0] wr_sel;

    // Out-of-range indices match no channel, so such writes fall through silently.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = div_wr && (div_ch == CH_IDX_W'(i));
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clkdiv_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en        (en[i]),
            .sync      (sync),
            .wr        (wr_sel[i]),
            .wr_val    (div_val),
            .clk_out   (clk_out[i]),
            .tick      (tick[i]),
            .pending   (pending[i])
`ifdef CLKDIV_CYCLE_CNT_EN
           ,.cycle_cnt (cycle_cnt[i*CYC_CNT_W +: CYC_CNT_W])
`endif
        );
    end

endmodule
